// File: rtl/canny_pkg.sv
// Shared definitions for the streaming Sobel/Canny gradient front end:
// FSM state encoding and the Sobel kernel weights.
package canny_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } canny_state_t;

    // Sobel 3x3 kernel: edge taps weigh 1, the centre tap of a row/column weighs 2.
    localparam int unsigned SOBEL_W_EDGE = 1;
    localparam int unsigned SOBEL_W_MID  = 2;

    // Cycles spent in DRAIN before returning to IDLE.
    localparam int unsigned DRAIN_CYCLES = 2;

endpackage

// File: rtl/canny_linebuf.sv
// One image row of pixel storage: one write and one asynchronous read per cycle,
// addressed by column, so a read returns the pixel of the previous row.
module canny_linebuf #(
    parameter int PIX_W = 16,
    parameter int IMG_W = 256,
    localparam int AW = (IMG_W > 1) ? $clog2(IMG_W) : 1
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    addr,
    input  logic [PIX_W-1:0] din,
    output logic [PIX_W-1:0] dout
);

    logic [PIX_W-1:0] mem [IMG_W];

    assign dout = mem[addr];

    // NOTE: storage is deliberately not reset; results are gated until every
    // window row has been written in the current frame, so stale rows never escape.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[addr] <= din;
        end
    end

endmodule

// File: rtl/canny_stream.sv
// Streaming 3x3 Sobel gradient engine: raster pixels in, |Gx|, |Gy|, signs and
// |Gx|+|Gy| out two cycles after each interior pixel. Optional threshold: CANNY_THRESH_EN.
module canny_stream
    import canny_pkg::*;
#(
    parameter int PIX_W = 16,
    parameter int IMG_W = 256,
    parameter int IMG_H = 256
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [PIX_W-1:0] pix_in,
    input  logic             pix_valid,
    output logic             pix_ready,
    output logic [PIX_W+1:0] dx_out,
    output logic             dx_out_sign,
    output logic [PIX_W+1:0] dy_out,
    output logic             dy_out_sign,
    output logic [PIX_W+2:0] dxy,
    output logic             data_occur,
`ifdef CANNY_THRESH_EN
    input  logic [PIX_W+2:0] thresh,
    output logic             edge_out,
`endif
    output logic             frame_done
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam int SW = PIX_W + 2;
    localparam int DW = PIX_W + 3;

    localparam logic [SW-1:0] K_EDGE = SW'(SOBEL_W_EDGE);
    localparam logic [SW-1:0] K_MID  = SW'(SOBEL_W_MID);

    canny_state_t state_q, state_d;
    logic         drain_q, drain_d;
    logic [CW-1:0] col_q;
    logic [RW-1:0] row_q;
    logic          accept;
    logic          last_pix;

    assign accept   = pix_valid & pix_ready;
    assign last_pix = (col_q == CW'(IMG_W - 1)) && (row_q == RW'(IMG_H - 1));

    // ------------------------------------------------------------------ FSM
    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            drain_q <= 1'b0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
        end
    end

    // NOTE: every output gets a default first, so no path infers a latch.
    always_comb begin
        state_d    = state_q;
        drain_d    = 1'b0;
        pix_ready  = 1'b0;
        frame_done = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                pix_ready = 1'b1;
                if (pix_valid && last_pix) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // drain_q marks the last of the DRAIN_CYCLES cycles
                if (drain_q) begin
                    state_d    = ST_IDLE;
                    frame_done = 1'b1;
                end else begin
                    drain_d = (DRAIN_CYCLES > 1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // ---------------------------------------------------------- raster position
    always_ff @(posedge clk) begin
        if (!reset) begin
            col_q <= '0;
            row_q <= '0;
        end else if (accept) begin
            if (col_q == CW'(IMG_W - 1)) begin
                col_q <= '0;
                row_q <= (row_q == RW'(IMG_H - 1)) ? '0 : row_q + RW'(1);
            end else begin
                col_q <= col_q + CW'(1);
            end
        end
    end

    // ----------------------------------------------------- line buffers + window
    logic [PIX_W-1:0] mid_pix;
    logic [PIX_W-1:0] top_pix;

    canny_linebuf #(.PIX_W(PIX_W), .IMG_W(IMG_W)) u_lb_mid (
        .clk   (clk),
        .wr_en (accept),
        .addr  (col_q),
        .din   (pix_in),
        .dout  (mid_pix)
    );

    canny_linebuf #(.PIX_W(PIX_W), .IMG_W(IMG_W)) u_lb_top (
        .clk   (clk),
        .wr_en (accept),
        .addr  (col_q),
        .din   (mid_pix),
        .dout  (top_pix)
    );

    // win[row][col]: row 0 = top, column 2 = newest (the accepted pixel's column)
    logic [PIX_W-1:0] win [3][3];
    logic             win_valid_q;

    always_ff @(posedge clk) begin
        if (accept) begin
            for (int r = 0; r < 3; r++) begin
                win[r][0] <= win[r][1];
                win[r][1] <= win[r][2];
            end
            win[0][2] <= top_pix;
            win[1][2] <= mid_pix;
            win[2][2] <= pix_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            win_valid_q <= 1'b0;
        end else begin
            win_valid_q <= accept && (col_q >= CW'(2)) && (row_q >= RW'(2));
        end
    end

    // ------------------------------------------------------------ Sobel maths
    logic [SW-1:0] sum_left, sum_right, sum_top, sum_bottom;
    logic          gx_neg, gy_neg;
    logic [SW-1:0] gx_mag, gy_mag;
    logic [DW-1:0] dxy_d;

    always_comb begin
        sum_left   = K_EDGE * SW'(win[0][0]) + K_MID * SW'(win[1][0]) + K_EDGE * SW'(win[2][0]);
        sum_right  = K_EDGE * SW'(win[0][2]) + K_MID * SW'(win[1][2]) + K_EDGE * SW'(win[2][2]);
        sum_top    = K_EDGE * SW'(win[0][0]) + K_MID * SW'(win[0][1]) + K_EDGE * SW'(win[0][2]);
        sum_bottom = K_EDGE * SW'(win[2][0]) + K_MID * SW'(win[2][1]) + K_EDGE * SW'(win[2][2]);
        // Subtract in the direction that cannot underflow; zero is reported positive.
        gx_neg = sum_left > sum_right;
        gy_neg = sum_top > sum_bottom;
        gx_mag = gx_neg ? (sum_left - sum_right) : (sum_right - sum_left);
        gy_mag = gy_neg ? (sum_top - sum_bottom) : (sum_bottom - sum_top);
        dxy_d  = {1'b0, gx_mag} + {1'b0, gy_mag};
    end

    // ---------------------------------------------------------- output stage
    always_ff @(posedge clk) begin
        if (!reset) begin
            data_occur  <= 1'b0;
            dx_out      <= '0;
            dx_out_sign <= 1'b0;
            dy_out      <= '0;
            dy_out_sign <= 1'b0;
            dxy         <= '0;
`ifdef CANNY_THRESH_EN
            edge_out    <= 1'b0;
`endif
        end else begin
            data_occur <= win_valid_q;
            if (win_valid_q) begin
                dx_out      <= gx_mag;
                dx_out_sign <= gx_neg;
                dy_out      <= gy_mag;
                dy_out_sign <= gy_neg;
                dxy         <= dxy_d;
`ifdef CANNY_THRESH_EN
                edge_out    <= (dxy_d >= thresh);
`endif
            end
        end
    end

endmodule

// File: doc/canny_stream.md
CANNY_STREAM -- requirements
Module: canny_stream

Interface
REQ-001 SHALL have parameter PIX_W, default 16, pixel width in bits.
REQ-002 SHALL have parameter IMG_W, default 256, pixels per row (min 3).
REQ-003 SHALL have parameter IMG_H, default 256, rows per frame (min 3).
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-006 SHALL have port start  input  1  begin frame when idle.
REQ-007 SHALL have port pix_in  input  PIX_W  raster-order pixel (row-major, top-left first).
REQ-008 SHALL have port pix_valid  input  1  pix_in valid this cycle.
REQ-009 SHALL have port pix_ready  output  1  block accepts pixel this cycle.
REQ-010 SHALL have port dx_out  output  PIX_W+2  |Gx| magnitude.
REQ-011 SHALL have port dx_out_sign  output  1  1 = Gx negative.
REQ-012 SHALL have port dy_out  output  PIX_W+2  |Gy| magnitude.
REQ-013 SHALL have port dy_out_sign  output  1  1 = Gy negative.
REQ-014 SHALL have port dxy  output  PIX_W+3  dx_out + dy_out.
REQ-015 SHALL have port data_occur  output  1  gradient outputs valid, one cycle per result.
REQ-016 SHALL have port frame_done  output  1  one-cycle pulse after last result of frame.

Function
REQ-017 FSM states IDLE, RUN, DRAIN; IDLE->RUN on start=1; RUN->DRAIN on acceptance of pixel (IMG_W-1, IMG_H-1); DRAIN->IDLE after 2 cycles, frame_done=1 in the DRAIN->IDLE cycle.
REQ-018 pix_ready SHALL be 1 only in RUN; pixel accepted when pix_valid & pix_ready.
REQ-019 start SHALL be ignored outside IDLE.
REQ-020 Column/row counters advance only on acceptance; col wraps IMG_W-1->0 and increments row.
REQ-021 Two line buffers (depth IMG_W) plus 3x3 shift window SHALL form the window with accepted pixel as bottom-right.
REQ-022 Result produced only when col>=2 and row>=2 at acceptance: (IMG_W-2)*(IMG_H-2) results per frame, no border outputs.
REQ-023 Gx = (right column, weights 1,2,1) - (left column, weights 1,2,1); Gy = (bottom row) - (top row), same weights.
REQ-024 Arithmetic exact, no saturation: magnitudes fit PIX_W+2, dxy fits PIX_W+3; sign=0 when value is 0.
REQ-025 Latency: data_occur and outputs asserted exactly 2 cycles after the accepting cycle; pix_valid gaps insert bubbles without altering results.
REQ-026 Outputs hold last value when data_occur=0.

Reset
REQ-027 reset=0 at rising edge SHALL force IDLE, counters 0, pipeline valids 0, all outputs 0, regardless of state.
REQ-028 Reset mid-frame SHALL abandon the frame; no frame_done; next start begins fresh frame at (0,0).
REQ-029 Line-buffer contents need not be cleared; stale data SHALL never reach outputs.

Configuration
REQ-030 Macro CANNY_THRESH_EN defined: add input thresh (PIX_W+3) and output edge_out (1) = (dxy >= thresh), registered with data_occur, reset 0.
REQ-031 Macro undefined: thresh and edge_out ports and logic absent; all else identical.

Structure
REQ-032 Shared package canny_pkg SHALL hold FSM state typedef and Sobel weight constants.
REQ-033 Line buffer SHALL be sub-module canny_linebuf (parameters PIX_W, IMG_W; 1-write/1-read per cycle).

Verification
REQ-034 IMG_W=IMG_H=4, all pixels 100 -> 4 results, all outputs 0, signs 0, one frame_done.
REQ-035 4x4, columns 0,0,10,10 -> 4 results dx_out=40, dx_out_sign=0, dy_out=0, dxy=40.
REQ-036 4x4, rows 10,10,0,0 -> 4 results dy_out=40, dy_out_sign=1, dxy=40.
REQ-037 4x4, left columns 0, right columns 0xFFFF -> dx_out=262140, dxy=262140, no overflow.
REQ-038 Random pix_valid gaps (50%) on REQ-035 image -> identical values, each 2 cycles after accepting pixel.
REQ-039 reset=0 mid-frame then full REQ-035 frame -> no frame_done for aborted frame, correct 4 results after; with CANNY_THRESH_EN, thresh=40 -> edge_out=1, thresh=41 -> 0.
